// File: rtl/max_pool_2x2_12ch.sv
// 2x2 stride-2 signed max pooling over 12 raster-order feature-map channels.
// One row of partial maxima per channel is kept, so no frame storage is needed.
module max_pool_2x2_12ch #(
  parameter int IN_Width  = 22,
  parameter int IN_Height = 22,
  parameter int Datawidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [Datawidth-1:0] In_0,
  input  logic [Datawidth-1:0] In_1,
  input  logic [Datawidth-1:0] In_2,
  input  logic [Datawidth-1:0] In_3,
  input  logic [Datawidth-1:0] In_4,
  input  logic [Datawidth-1:0] In_5,
  input  logic [Datawidth-1:0] In_6,
  input  logic [Datawidth-1:0] In_7,
  input  logic [Datawidth-1:0] In_8,
  input  logic [Datawidth-1:0] In_9,
  input  logic [Datawidth-1:0] In_10,
  input  logic [Datawidth-1:0] In_11,
  output logic                 valid_out,
  output logic                 last_out,
  output logic [Datawidth-1:0] Out_0,
  output logic [Datawidth-1:0] Out_1,
  output logic [Datawidth-1:0] Out_2,
  output logic [Datawidth-1:0] Out_3,
  output logic [Datawidth-1:0] Out_4,
  output logic [Datawidth-1:0] Out_5,
  output logic [Datawidth-1:0] Out_6,
  output logic [Datawidth-1:0] Out_7,
  output logic [Datawidth-1:0] Out_8,
  output logic [Datawidth-1:0] Out_9,
  output logic [Datawidth-1:0] Out_10,
  output logic [Datawidth-1:0] Out_11
);

  localparam int NCH = 12;
  localparam int WP  = IN_Width / 2;
  localparam int HP  = IN_Height / 2;
  localparam int CW  = $clog2(IN_Width + 1);
  localparam int RW  = $clog2(IN_Height + 1);
  localparam int AW  = (WP > 1) ? $clog2(WP) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_Height - 1);
  localparam logic [CW-1:0] COL_END  = CW'(2 * WP);
  localparam logic [RW-1:0] ROW_END  = RW'(2 * HP);
  localparam logic [CW-1:0] COL_WIN  = CW'(2 * WP - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2 * HP - 1);

  typedef logic signed [Datawidth-1:0] sample_t;

  sample_t       in_a    [NCH];
  sample_t       h_q     [NCH];
  sample_t       h_d     [NCH];
  sample_t       out_q   [NCH];
  sample_t       out_d   [NCH];
  sample_t       lb_q    [WP][NCH];
  sample_t       lb_wdata[NCH];
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_out_q, valid_out_d;
  logic          last_out_q, last_out_d;
  logic          in_region;

  assign in_a[0]  = In_0;
  assign in_a[1]  = In_1;
  assign in_a[2]  = In_2;
  assign in_a[3]  = In_3;
  assign in_a[4]  = In_4;
  assign in_a[5]  = In_5;
  assign in_a[6]  = In_6;
  assign in_a[7]  = In_7;
  assign in_a[8]  = In_8;
  assign in_a[9]  = In_9;
  assign in_a[10] = In_10;
  assign in_a[11] = In_11;

  assign Out_0  = out_q[0];
  assign Out_1  = out_q[1];
  assign Out_2  = out_q[2];
  assign Out_3  = out_q[3];
  assign Out_4  = out_q[4];
  assign Out_5  = out_q[5];
  assign Out_6  = out_q[6];
  assign Out_7  = out_q[7];
  assign Out_8  = out_q[8];
  assign Out_9  = out_q[9];
  assign Out_10 = out_q[10];
  assign Out_11 = out_q[11];

  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  // Odd trailing row/column of an odd-sized map is counted but never pooled.
  assign in_region = (col_q < COL_END) && (row_q < ROW_END);
  assign lb_addr   = AW'(col_q >> 1);

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    h_d         = h_q;
    out_d       = out_q;
    valid_out_d = 1'b0;
    last_out_d  = 1'b0;
    lb_we       = 1'b0;
    for (int k = 0; k < NCH; k++) lb_wdata[k] = '0;

    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (in_region) begin
        if (!col_q[0]) begin
          for (int k = 0; k < NCH; k++) h_d[k] = in_a[k];
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
          for (int k = 0; k < NCH; k++) lb_wdata[k] = smax(h_q[k], in_a[k]);
        end else begin
          valid_out_d = 1'b1;
          last_out_d  = (row_q == ROW_WIN) && (col_q == COL_WIN);
          for (int k = 0; k < NCH; k++)
            out_d[k] = smax(lb_q[lb_addr][k], smax(h_q[k], in_a[k]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        h_q[k]   <= '0;
        out_q[k] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      h_q         <= h_d;
      out_q       <= out_d;
    end
  end

  // Line buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      for (int k = 0; k < NCH; k++) lb_q[lb_addr][k] <= lb_wdata[k];
    end
  end

endmodule

// File: tb/tb_max_pool_2x2_12ch.sv
// Directed bench for max_pool_2x2_12ch: 22x22 default instance plus a 5x5 instance.
module tb_max_pool_2x2_12ch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic        vin5 = 1'b0;
  logic [31:0] in_a [12];
  logic [31:0] in5  [12];
  wire  [31:0] out_w [12];
  wire  [31:0] out5  [12];
  wire         vout, lout, vout5, lout5;

  int tests = 0;
  int fails = 0;

  int q0[$];
  bit ql[$];
  bit qeq[$];
  bit qz[$];
  int q5[$];
  bit ql5[$];

  always #5 clk = ~clk;

  max_pool_2x2_12ch dut (
    .clk(clk), .rst(rst), .valid_in(vin),
    .In_0(in_a[0]), .In_1(in_a[1]), .In_2(in_a[2]), .In_3(in_a[3]),
    .In_4(in_a[4]), .In_5(in_a[5]), .In_6(in_a[6]), .In_7(in_a[7]),
    .In_8(in_a[8]), .In_9(in_a[9]), .In_10(in_a[10]), .In_11(in_a[11]),
    .valid_out(vout), .last_out(lout),
    .Out_0(out_w[0]), .Out_1(out_w[1]), .Out_2(out_w[2]), .Out_3(out_w[3]),
    .Out_4(out_w[4]), .Out_5(out_w[5]), .Out_6(out_w[6]), .Out_7(out_w[7]),
    .Out_8(out_w[8]), .Out_9(out_w[9]), .Out_10(out_w[10]), .Out_11(out_w[11])
  );

  max_pool_2x2_12ch #(.IN_Width(5), .IN_Height(5), .Datawidth(32)) dut5 (
    .clk(clk), .rst(rst), .valid_in(vin5),
    .In_0(in5[0]), .In_1(in5[1]), .In_2(in5[2]), .In_3(in5[3]),
    .In_4(in5[4]), .In_5(in5[5]), .In_6(in5[6]), .In_7(in5[7]),
    .In_8(in5[8]), .In_9(in5[9]), .In_10(in5[10]), .In_11(in5[11]),
    .valid_out(vout5), .last_out(lout5),
    .Out_0(out5[0]), .Out_1(out5[1]), .Out_2(out5[2]), .Out_3(out5[3]),
    .Out_4(out5[4]), .Out_5(out5[5]), .Out_6(out5[6]), .Out_7(out5[7]),
    .Out_8(out5[8]), .Out_9(out5[9]), .Out_10(out5[10]), .Out_11(out5[11])
  );

  // Capture every pooled beat away from the rising edge.
  always @(negedge clk) begin : monitor
    bit eq, z;
    if (vout === 1'b1) begin
      eq = 1'b1;
      z  = 1'b1;
      for (int k = 1; k < 12; k++) begin
        if (out_w[k] !== out_w[0]) eq = 1'b0;
        if (out_w[k] !== 32'd0) z = 1'b0;
      end
      q0.push_back(int'($signed(out_w[0])));
      ql.push_back(lout);
      qeq.push_back(eq);
      qz.push_back(z);
    end
    if (vout5 === 1'b1) begin
      q5.push_back(int'($signed(out5[0])));
      ql5.push_back(lout5);
    end
  end

  function automatic logic [31:0] pix(input int kind, input int x, input int y, input int ch);
    case (kind)
      0: return 32'(y * 22 + x + 1);
      1: return 32'(1000 - (y * 22 + x));
      2: begin
        if (ch != 0) return 32'd0;
        return (y == 1 && x == 0) ? 32'(-3) : 32'(-5);
      end
      default: return 32'(y * 5 + x + 1);
    endcase
  endfunction

  function automatic int qat(input int i);
    return (i < q0.size()) ? q0[i] : 32'h7fff_0000;
  endfunction

  function automatic int q5at(input int i);
    return (i < q5.size()) ? q5[i] : 32'h7fff_0000;
  endfunction

  function automatic int count_last();
    int n = 0;
    foreach (ql[i]) if (ql[i]) n++;
    return n;
  endfunction

  task automatic put(input int kind, input int x, input int y);
    vin = 1'b1;
    for (int k = 0; k < 12; k++) in_a[k] = pix(kind, x, y, k);
  endtask

  task automatic put5(input int x, input int y);
    vin5 = 1'b1;
    for (int k = 0; k < 12; k++) in5[k] = pix(3, x, y, k);
  endtask

  task automatic clear_q();
    q0.delete(); ql.delete(); qeq.delete(); qz.delete();
  endtask

  task automatic send_frame(input int kind);
    for (int y = 0; y < 22; y++)
      for (int x = 0; x < 22; x++) begin
        @(negedge clk);
        put(kind, x, y);
      end
    @(negedge clk);
    vin = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests++;
    if (vout !== 1'b0 || lout !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags got valid=%b last=%b want 0 0", vout, lout);
    end
    tests++;
    if (out_w[0] !== 32'd0 || out_w[11] !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_out got %0h %0h want 0 0", out_w[0], out_w[11]);
    end
    tests++;
    if (vout5 !== 1'b0 || out5[0] !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_dut5 got valid=%b out=%0h want 0 0", vout5, out5[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp();
    int bad;
    clear_q();
    send_frame(0);
    tests++;
    if (q0.size() !== 121) begin fails++; $display("[TB] FAIL ramp_count got %0d want 121", q0.size()); end
    tests++;
    if (qat(0) !== 24 || qat(1) !== 26) begin
      fails++; $display("[TB] FAIL ramp_first got %0d %0d want 24 26", qat(0), qat(1));
    end
    tests++;
    if (qat(10) !== 44 || qat(11) !== 68) begin
      fails++; $display("[TB] FAIL ramp_row_wrap got %0d %0d want 44 68", qat(10), qat(11));
    end
    tests++;
    if (qat(120) !== 484 || q0.size() < 121 || ql[q0.size()-1] !== 1'b1) begin
      fails++; $display("[TB] FAIL ramp_final got %0d want 484 with last", qat(120));
    end
    tests++;
    if (count_last() !== 1) begin fails++; $display("[TB] FAIL ramp_last_count got %0d want 1", count_last()); end
    bad = 0;
    foreach (qeq[i]) if (!qeq[i]) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("[TB] FAIL ramp_channels_equal got %0d unequal beats want 0", bad); end
  endtask

  task automatic test_descending();
    clear_q();
    send_frame(1);
    tests++;
    if (q0.size() !== 121) begin fails++; $display("[TB] FAIL desc_count got %0d want 121", q0.size()); end
    tests++;
    if (qat(0) !== 1000 || qat(1) !== 998 || qat(11) !== 956) begin
      fails++; $display("[TB] FAIL desc_values got %0d %0d %0d want 1000 998 956", qat(0), qat(1), qat(11));
    end
  endtask

  task automatic test_signed();
    int bad, nz;
    clear_q();
    send_frame(2);
    tests++;
    if (qat(0) !== -3) begin fails++; $display("[TB] FAIL signed_first got %0d want -3", qat(0)); end
    bad = 0;
    for (int i = 1; i < q0.size(); i++) if (q0[i] !== -5) bad++;
    tests++;
    if (bad !== 0 || q0.size() !== 121) begin
      fails++; $display("[TB] FAIL signed_rest got %0d wrong of %0d want 0 of 121", bad, q0.size());
    end
    nz = 0;
    foreach (qz[i]) if (!qz[i]) nz++;
    tests++;
    if (nz !== 0) begin fails++; $display("[TB] FAIL signed_other_ch got %0d nonzero beats want 0", nz); end
  endtask

  task automatic test_odd_size();
    q5.delete(); ql5.delete();
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) begin
          @(negedge clk);
          put5(x, y);
        end
    @(negedge clk);
    vin5 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (q5.size() !== 8) begin fails++; $display("[TB] FAIL odd_count got %0d want 8", q5.size()); end
    tests++;
    if (q5at(0) !== 7 || q5at(1) !== 9 || q5at(2) !== 17 || q5at(3) !== 19) begin
      fails++; $display("[TB] FAIL odd_values got %0d %0d %0d %0d want 7 9 17 19", q5at(0), q5at(1), q5at(2), q5at(3));
    end
    tests++;
    if (q5.size() < 8 || ql5[0] || ql5[1] || ql5[2] || !ql5[3] || !ql5[7] || ql5[4]) begin
      fails++; $display("[TB] FAIL odd_last got pattern size %0d want last only on 19", q5.size());
    end
    tests++;
    if (q5at(4) !== 7 || q5at(7) !== 19) begin
      fails++; $display("[TB] FAIL odd_restart got %0d %0d want 7 19", q5at(4), q5at(7));
    end
  endtask

  task automatic test_gapped();
    int bad, lat_bad;
    bit exp;
    clear_q();
    lat_bad = 0;
    for (int y = 0; y < 22; y++)
      for (int x = 0; x < 22; x++) begin
        @(negedge clk);
        if (vout !== 1'b0) lat_bad++;
        put(0, x, y);
        @(negedge clk);
        exp = (y % 2 == 1) && (x % 2 == 1);
        if (vout !== exp) lat_bad++;
        vin = 1'b0;
      end
    repeat (3) @(negedge clk);
    tests++;
    if (q0.size() !== 121) begin fails++; $display("[TB] FAIL gap_count got %0d want 121", q0.size()); end
    bad = 0;
    for (int n = 0; n < 121; n++)
      if (qat(n) !== (2 * (n / 11) + 1) * 22 + 2 * (n % 11) + 2) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("[TB] FAIL gap_values got %0d wrong want 0", bad); end
    tests++;
    if (lat_bad !== 0) begin fails++; $display("[TB] FAIL gap_latency got %0d misplaced pulses want 0", lat_bad); end
  endtask

  task automatic test_reset_mid();
    int beats;
    beats = 0;
    for (int y = 0; y < 22 && beats < 100; y++)
      for (int x = 0; x < 22 && beats < 100; x++) begin
        @(negedge clk);
        put(0, x, y);
        beats++;
      end
    @(negedge clk);
    vin = 1'b0;
    tests++;
    if (out_w[0] !== 32'd88) begin fails++; $display("[TB] FAIL midreset_pre got %0d want 88", out_w[0]); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (vout !== 1'b0 || out_w[0] !== 32'd0 || out_w[7] !== 32'd0) begin
      fails++; $display("[TB] FAIL midreset_async got valid=%b out=%0d want 0 0", vout, out_w[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_q();
    send_frame(0);
    tests++;
    if (qat(0) !== 24 || q0.size() !== 121) begin
      fails++; $display("[TB] FAIL midreset_restart got first %0d count %0d want 24 121", qat(0), q0.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 12; k++) begin
      in_a[k] = '0;
      in5[k]  = '0;
    end
    test_reset();
    test_ramp();
    test_descending();
    test_signed();
    test_odd_size();
    test_gapped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2_12ch.md
Name: max_pool_2x2_12ch

Overview:
Downstream stage of the 12-layer, 4-channel, 3x3 2D convolution block. It consumes the convolution's raster-order output stream: 12 parallel feature-map channels, one pixel per valid beat. It performs 2x2, stride-2 max pooling on every channel and emits the pooled raster stream with a per-beat valid and a frame-last flag. A single row of partial maxima is buffered per channel, so pooling runs on-the-fly with no frame storage.

Parameters:
IN_Width, 22, width of incoming feature map (3x3 conv, stride 1, on a 24-wide image).
IN_Height, 22, height of incoming feature map.
Datawidth, 32, bits per sample; samples are signed two's complement.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
valid_in  input  1  In_0..In_11 carry one pixel this cycle.
In_0..In_11  input  Datawidth each  channel k sample, same pixel position on all channels.
valid_out  output  1  Out_0..Out_11 hold one pooled pixel this cycle.
last_out  output  1  qualifies the final pooled pixel of a frame.
Out_0..Out_11  output  Datawidth each  channel k pooled maximum.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst=0: valid_out=0, last_out=0, Out_0..Out_11=0, col/row counters=0, hold registers=0. Line-buffer contents are don't-care.
- Reset asserted mid-frame aborts the frame. After release, the first valid_in beat is pixel (row 0, col 0).
- Stream counters: col 0..IN_Width-1 and row 0..IN_Height-1 advance only on valid_in=1. After (IN_Height-1, IN_Width-1), both wrap to 0 and the next frame starts.
- Gaps: valid_in may drop for any number of cycles; all state holds. There is no backpressure, so the consumer must accept every valid_out beat.
- Pool region: Wp = floor(IN_Width/2), Hp = floor(IN_Height/2). If IN_Width is odd, the last column is counted but ignored. If IN_Height is odd, the last row is counted but ignored.
- Per channel, independently, for pixels inside the pool region:
  - Even row, even col: h <= x.
  - Even row, odd col: lb[col>>1] <= max(h, x).
  - Odd row, even col: h <= x.
  - Odd row, odd col: Out <= max(lb[col>>1], h, x), and valid_out <= 1.
- Comparisons are signed, Datawidth bits. Equal values may select any operand.
- Latency: valid_out and Out are registered, asserted the cycle after the valid_in beat that completes a window.
- valid_out is a single-cycle pulse per window; Out holds its value until the next pooled result.
- last_out=1 together with valid_out for window (Hp-1, Wp-1); otherwise last_out=0.
- Each frame produces exactly Wp*Hp valid_out pulses.
- Line buffer: Wp entries x 12 channels x Datawidth. Any RAM/reg style is acceptable. A write (even row) and a read (odd row) never occur in the same cycle.
- Target size: 120-400 lines RTL.

Test Plan:
- Ramp, defaults (22x22): In_k = y*22+x+1 for all k, valid_in continuous.
  - Required: 121 pulses; first Out=24, second 26, 11th 44, 12th 68.
  - Final Out=484 with last_out=1; all 12 channels identical.
- Descending ramp: In_k = 1000-(y*22+x).
  - Required: first Out=1000, second 998, 12th 956.
  - Checks top-left selection.
- Signed compare: channel 0 all -5 except pixel (1,0) = -3; other channels 0.
  - Required: window (0,0) Out_0=-3, every other Out_0=-5; Out_1..Out_11 always 0.
- Odd size, IN_Width=IN_Height=5, ramp y*5+x+1.
  - Required: exactly 4 outputs: 7, 9, 17, 19; last_out only on 19.
  - Column 4 and row 4 are ignored; the next frame restarts at 7.
- Gapped input: defaults ramp with valid_in toggling 1/0 every cycle.
  - Required: same 121 values and order as the ramp case; each valid_out exactly one cycle after its completing beat.
- Reset mid-frame: assert rst=0 for 2 cycles after 100 beats.
  - Required: valid_out=0 and Out=0 immediately (asynchronous).
  - After release, a restarted ramp yields first Out=24 and exactly 121 outputs.
